// File: rtl/solomon_rom_pkg.sv
// Shared widths, FSM encoding and default image size for the ROM-download sender.
package solomon_rom_pkg;
    localparam int ROM_AW = 20;
    localparam int ROM_DW = 8;
    localparam logic [ROM_AW-1:0] ROM_BYTES_DEF = 20'hC000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;
endpackage

// File: rtl/solomon_rom_fifo.sv
// Small synchronous byte FIFO with flush; read data is shown from the head entry without a pop.
module solomon_rom_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A pop frees the head slot, so a push is accepted even when full.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/solomon_rom_sender.sv
// ROMCL/ROMAD/ROMDT/ROMEN download sender: buffers host bytes and emits paced, addressed write strobes.
// Optional ROM_CHECKSUM_EN adds a running 16-bit CSUM of all written bytes.
module solomon_rom_sender
    import solomon_rom_pkg::*;
#(
    parameter int                FIFO_DEPTH = 4,
    parameter int                PACE       = 8,
    parameter logic [ROM_AW-1:0] ROM_BYTES  = ROM_BYTES_DEF
) (
    input  logic              MCLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic [ROM_DW-1:0] HDT,
    input  logic              HVALID,
    output logic              HREADY,
    input  logic              HLAST,
    output logic [ROM_AW-1:0] ROMAD,
    output logic [ROM_DW-1:0] ROMDT,
    output logic              ROMEN,
    output logic              BUSY,
    output logic              DONE,
`ifdef ROM_CHECKSUM_EN
    output logic              OVF,
    output logic [15:0]       CSUM
`else
    output logic              OVF
`endif
);
    localparam int            PW        = $clog2(PACE);
    localparam logic [PW-1:0] PACE_LOAD = PW'(PACE - 1);

    state_t            state;
    logic [PW-1:0]     pace;
    logic [ROM_AW-1:0] addr;
    logic              last_seen;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ROM_DW-1:0] fifo_dout;
    logic              accept;
    logic              pop;

    assign HREADY = (state == ST_RUN) && !fifo_full && !last_seen;
    assign BUSY   = (state == ST_RUN);
    // A beat coinciding with START belongs to the aborted session and is dropped.
    assign accept = HVALID && HREADY && !START;
    assign pop    = (state == ST_RUN) && !START && !fifo_empty && (pace == '0);

    solomon_rom_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ROM_DW)
    ) u_fifo (
        .clk   (MCLK),
        .rst_n (RESET_N),
        .flush (START),
        .push  (accept),
        .din   (HDT),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= ST_IDLE;
            pace      <= '0;
            addr      <= '0;
            last_seen <= 1'b0;
            ROMAD     <= '0;
            ROMDT     <= '0;
            ROMEN     <= 1'b0;
            DONE      <= 1'b0;
            OVF       <= 1'b0;
`ifdef ROM_CHECKSUM_EN
            CSUM      <= '0;
`endif
        end else begin
            ROMEN <= 1'b0;
            if (pace != '0) pace <= pace - 1'b1;

            if (START) begin
                state     <= ST_RUN;
                pace      <= '0;
                addr      <= '0;
                last_seen <= 1'b0;
                DONE      <= 1'b0;
                OVF       <= 1'b0;
`ifdef ROM_CHECKSUM_EN
                CSUM      <= '0;
`endif
            end else if (state == ST_RUN) begin
                if (accept && HLAST) last_seen <= 1'b1;
                if (pop) begin
                    pace <= PACE_LOAD;
                    // Past the image end the byte is consumed but never strobed; addr stays saturated.
                    if (addr < ROM_BYTES) begin
                        ROMAD <= addr;
                        ROMDT <= fifo_dout;
                        ROMEN <= 1'b1;
                        addr  <= addr + 1'b1;
`ifdef ROM_CHECKSUM_EN
                        CSUM  <= CSUM + {8'h00, fifo_dout};
`endif
                    end else begin
                        OVF <= 1'b1;
                    end
                end else if (last_seen && fifo_empty) begin
                    state <= ST_DONE;
                    DONE  <= 1'b1;
                end
            end
        end
    end
endmodule
